// File: rtl/pm_dump_tx_if.sv
// pm_dump_tx_if: groups the program-memory read port and the UART TX byte
// port used by the dump engine.
//   master (dump engine): drives addr_rd, rd_ins, data_bus_in, TX_use;
//                         samples rd_idle, data_bus_rd, TX_complete.
//   slave  (memory/UART): the mirror image.
interface pm_dump_tx_if #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH        = 8
);

  // Program-memory read port
  logic [ADDR_WIDTH-1:0]        addr_rd;
  logic                         rd_ins;
  logic                         rd_idle;
  logic [INSTRUCTION_WIDTH-1:0] data_bus_rd;

  // UART TX byte port
  logic [DATA_WIDTH-1:0]        data_bus_in;
  logic                         TX_use;
  logic                         TX_complete;

  modport master (
    output addr_rd,
    output rd_ins,
    input  rd_idle,
    input  data_bus_rd,
    output data_bus_in,
    output TX_use,
    input  TX_complete
  );

  modport slave (
    input  addr_rd,
    input  rd_ins,
    output rd_idle,
    output data_bus_rd,
    input  data_bus_in,
    input  TX_use,
    output TX_complete
  );

endinterface

// File: rtl/pm_dump_tx.sv
// pm_dump_tx: program-memory readback engine. On start it reads word_count
// consecutive 32-bit words beginning at the word-aligned start_addr and
// streams each word to the UART transmitter as 4 bytes, LSB first.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle request, honoured only while idle
//   start_addr        byte address of the first word (bits [1:0] ignored)
//   word_count        number of words to dump (0 = immediate done)
//   busy              high while a dump is in progress
//   done              one-cycle pulse at the end of a dump
//   bus (master)      memory read port + UART TX byte port
//
// Optional feature (macro PM_DUMP_CHECKSUM_EN): after the last data byte a
// single extra byte is sent carrying the 8-bit modulo-256 sum of every data
// byte of this dump.
module pm_dump_tx #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned COUNT_WIDTH       = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  pm_dump_tx_if.master           bus
);

  localparam int unsigned BYTES_PER_WORD = INSTRUCTION_WIDTH / DATA_WIDTH;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  if (INSTRUCTION_WIDTH != 4 * DATA_WIDTH) begin : g_width_check
    $error("pm_dump_tx: INSTRUCTION_WIDTH must equal 4*DATA_WIDTH");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RD,
    S_SEND,
    S_WAIT_TX,
    S_NEXT,
`ifdef PM_DUMP_CHECKSUM_EN
    S_CSUM,
    S_CSUM_WAIT,
`endif
    S_DONE
  } state_t;

  state_t                       state;
  logic [COUNT_WIDTH-1:0]       remaining;
  logic [INSTRUCTION_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]             byte_idx;
  logic                         rd_seen_low;
`ifdef PM_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]        csum_q;
`endif

  // Dump sequencer: one outstanding read, then four one-at-a-time UART bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      remaining       <= '0;
      shift_q         <= '0;
      byte_idx        <= '0;
      rd_seen_low     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      bus.addr_rd     <= '0;
      bus.rd_ins      <= 1'b0;
      bus.data_bus_in <= '0;
      bus.TX_use      <= 1'b0;
`ifdef PM_DUMP_CHECKSUM_EN
      csum_q          <= '0;
`endif
    end else begin
      // Strobes default low every cycle.
      done       <= 1'b0;
      bus.rd_ins <= 1'b0;
      bus.TX_use <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              // Word-align the start address by clearing the two LSBs.
              bus.addr_rd <= start_addr & ~ADDR_WIDTH'(3);
              remaining   <= word_count;
              busy        <= 1'b1;
              state       <= S_REQ;
`ifdef PM_DUMP_CHECKSUM_EN
              csum_q      <= '0;
`endif
            end
          end
        end

        S_REQ: begin
          if (bus.rd_idle) begin
            bus.rd_ins  <= 1'b1;
            rd_seen_low <= 1'b0;
            state       <= S_WAIT_RD;
          end
        end

        // Data is valid on the first idle cycle after the port went busy.
        S_WAIT_RD: begin
          if (!bus.rd_idle) begin
            rd_seen_low <= 1'b1;
          end else if (rd_seen_low) begin
            shift_q  <= bus.data_bus_rd;
            byte_idx <= '0;
            state    <= S_SEND;
          end
        end

        S_SEND: begin
          bus.data_bus_in <= shift_q[DATA_WIDTH-1:0];
          bus.TX_use      <= 1'b1;
`ifdef PM_DUMP_CHECKSUM_EN
          csum_q          <= csum_q + shift_q[DATA_WIDTH-1:0];
`endif
          state           <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (bus.TX_complete) begin
            shift_q  <= shift_q >> DATA_WIDTH;
            byte_idx <= byte_idx + IDX_W'(1);
            if (byte_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
              state <= S_NEXT;
            end else begin
              state <= S_SEND;
            end
          end
        end

        // Address wraps naturally at the top of the byte-address space.
        S_NEXT: begin
          bus.addr_rd <= bus.addr_rd + ADDR_WIDTH'(4);
          remaining   <= remaining - COUNT_WIDTH'(1);
          if (remaining == COUNT_WIDTH'(1)) begin
`ifdef PM_DUMP_CHECKSUM_EN
            state <= S_CSUM;
`else
            state <= S_DONE;
`endif
          end else begin
            state <= S_REQ;
          end
        end

`ifdef PM_DUMP_CHECKSUM_EN
        S_CSUM: begin
          bus.data_bus_in <= csum_q;
          bus.TX_use      <= 1'b1;
          state           <= S_CSUM_WAIT;
        end

        S_CSUM_WAIT: begin
          if (bus.TX_complete) begin
            state <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pm_dump_tx.sv
// tb_pm_dump_tx: scoreboard bench for pm_dump_tx. Expected read addresses,
// TX bytes and done pulses are queued when a dump is launched; a negedge
// monitor pops and compares whenever the DUT strobes rd_ins, TX_use or done.
// Memory and UART behavioural models drive the slave side of the interface.
// Honours PM_DUMP_CHECKSUM_EN by appending the expected checksum byte.
module tb_pm_dump_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy;
  logic          done;

  pm_dump_tx_if #(.DATA_WIDTH(DW), .INSTRUCTION_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  pm_dump_tx #(
    .DATA_WIDTH(DW), .INSTRUCTION_WIDTH(IW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_tx[$];
  logic [AW-1:0] exp_rd[$];
  int            exp_done = 0;
  int            tx_seen  = 0;

  logic [IW-1:0] mem [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h, required no event", name, act);
  endtask

  // ---------------- memory model ----------------
  int rd_lat = 1;
  int rd_cnt = 0;
  bit rd_block = 1'b0;

  initial begin
    bus.rd_idle     = 1'b1;
    bus.data_bus_rd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_cnt      = 0;
        bus.rd_idle = !rd_block;
      end else if (bus.rd_ins) begin
        if (!bus.rd_idle) flag("rd_ins_while_not_idle", {24'h0, bus.addr_rd});
        bus.data_bus_rd = mem[bus.addr_rd[7:2]];
        rd_cnt          = rd_lat;
        bus.rd_idle     = 1'b0;
      end else begin
        if (rd_cnt > 0) rd_cnt--;
        bus.rd_idle = (rd_cnt == 0) && !rd_block;
      end
    end
  end

  // ---------------- UART TX model ----------------
  int tx_lat = 2;
  int tx_cnt = 0;
  bit tx_busy = 1'b0;

  initial begin
    bus.TX_complete = 1'b0;
    forever begin
      @(negedge clk);
      bus.TX_complete = 1'b0;
      if (!rst_n) begin
        tx_busy = 1'b0;
        tx_cnt  = 0;
      end else begin
        if (tx_busy) begin
          tx_cnt--;
          if (tx_cnt == 0) begin
            bus.TX_complete = 1'b1;
            tx_busy         = 1'b0;
          end
        end
        if (bus.TX_use) begin
          if (tx_busy) flag("tx_use_before_complete", {24'h0, bus.data_bus_in});
          tx_busy = 1'b1;
          tx_cnt  = tx_lat;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_ins === 1'b1) begin
        if (exp_rd.size() == 0) flag("rd_ins_unexpected", {24'h0, bus.addr_rd});
        else check("rd_addr", {24'h0, bus.addr_rd}, {24'h0, exp_rd.pop_front()});
      end
      if (bus.TX_use === 1'b1) begin
        tx_seen++;
        if (exp_tx.size() == 0) flag("tx_use_unexpected", {24'h0, bus.data_bus_in});
        else check("tx_byte", {24'h0, bus.data_bus_in}, {24'h0, exp_tx.pop_front()});
      end
      if (done === 1'b1) begin
        if (exp_done == 0) flag("done_unexpected", 32'h1);
        else begin
          exp_done--;
          check("busy_at_done", {31'h0, busy}, 32'h0);
        end
      end
    end
  end

  // Queue the expected reads, bytes (and checksum) for one dump.
  task automatic expect_dump(input logic [AW-1:0] addr, input int cnt);
    logic [AW-1:0] a;
    logic [IW-1:0] w;
    logic [DW-1:0] sum;
    a   = addr & 8'hFC;
    sum = '0;
    for (int i = 0; i < cnt; i++) begin
      exp_rd.push_back(a);
      w = mem[a[7:2]];
      for (int b = 0; b < 4; b++) begin
        exp_tx.push_back(w[b*8 +: 8]);
        sum = sum + w[b*8 +: 8];
      end
      a = a + 8'd4;
    end
`ifdef PM_DUMP_CHECKSUM_EN
    if (cnt > 0) exp_tx.push_back(sum);
`endif
    exp_done++;
  endtask

  task automatic do_start(input logic [AW-1:0] addr, input int cnt);
    @(negedge clk);
    start      = 1'b1;
    start_addr = addr;
    word_count = CW'(cnt);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (exp_done != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_done != 0) begin
      flag({name, "_timeout"}, n);
      exp_done = 0;
    end
    check({name, "_tx_left"}, exp_tx.size(), 0);
    check({name, "_rd_left"}, exp_rd.size(), 0);
    check({name, "_busy_after"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},    {31'h0, busy}, 32'h0);
    check({name, "_done"},    {31'h0, done}, 32'h0);
    check({name, "_rd_ins"},  {31'h0, bus.rd_ins}, 32'h0);
    check({name, "_tx_use"},  {31'h0, bus.TX_use}, 32'h0);
    check({name, "_addr_rd"}, {24'h0, bus.addr_rd}, 32'h0);
    check({name, "_data_in"}, {24'h0, bus.data_bus_in}, 32'h0);
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD0000 | 32'(i);
    mem[4]  = 32'hA1B2C3D4;
    mem[63] = 32'h11223344;
    mem[0]  = 32'h55667788;
    mem[16] = 32'h0BADF00D;
    mem[17] = 32'hCAFE1234;
    mem[12] = 32'h76543210;
    mem[13] = 32'hFEDCBA98;
    mem[8]  = 32'h01020304;

    // Power-on reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word at 0x10
    expect_dump(8'h10, 1);
    do_start(8'h10, 1);
    check("single_busy_after_start", {31'h0, busy}, 32'h1);
    wait_done("single", 300);

    // Two words wrapping from 0xFC to 0x00
    expect_dump(8'hFC, 2);
    do_start(8'hFC, 2);
    wait_done("wrap", 500);

    // Zero count: done next cycle, no traffic
    exp_done++;
    do_start(8'h20, 0);
    check("zero_done", {31'h0, done}, 32'h1);
    check("zero_busy", {31'h0, busy}, 32'h0);
    repeat (10) @(negedge clk);
    wait_done("zero", 5);

    // Backpressure: slow memory, slow UART, ignored starts while busy
    rd_block = 1'b1;
    rd_lat   = 3;
    tx_lat   = 20;
    expect_dump(8'h40, 2);
    do_start(8'h40, 2);
    repeat (2) @(negedge clk);
    start = 1'b1; start_addr = 8'h80; word_count = CW'(5);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rd_block = 1'b0;
    repeat (30) @(negedge clk);
    start = 1'b1; start_addr = 8'h90; word_count = CW'(3);
    @(negedge clk);
    start = 1'b0;
    check("bp_busy_mid", {31'h0, busy}, 32'h1);
    wait_done("backpressure", 1500);
    rd_lat = 1;
    tx_lat = 2;

    // Reset mid-dump after the second byte
    expect_dump(8'h30, 2);
    base = tx_seen;
    do_start(8'h30, 2);
    n = 0;
    while (tx_seen < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx_seen < base + 2) flag("midreset_wait_timeout", n);
    rst_n = 1'b0;
    exp_tx.delete();
    exp_rd.delete();
    exp_done = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    wait_done("midreset_quiet", 5);

    // Recovery with unaligned start address (0x13 -> 0x10)
    expect_dump(8'h13, 1);
    do_start(8'h13, 1);
    wait_done("unaligned", 300);

    // Word 0x01020304 (checksum 0x0A when enabled)
    expect_dump(8'h20, 1);
    do_start(8'h20, 1);
    wait_done("csum_word", 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pm_dump_tx.md
Name: pm_dump_tx

Overview:
- Readback engine that streams program-memory contents out over a UART transmitter, one instruction word at a time.
- On a start strobe it reads N consecutive 32-bit words from the program memory read port and emits each word as 4 bytes, LSB first, through the UART TX byte interface.
- It is the reader/transmit counterpart of the UART_1 program-load path, used for load verification and debug dump.

Parameters:
- DATA_WIDTH, 8, UART byte width.
- INSTRUCTION_WIDTH, 32, program word width; must be 4*DATA_WIDTH.
- ADDR_WIDTH, 8, width of program-memory byte address.
- COUNT_WIDTH, 9, width of word_count.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- start_addr  input  ADDR_WIDTH  byte address of first word; bits [1:0] ignored (forced 0).
- word_count  input  COUNT_WIDTH  number of words to send.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the dump finishes.
- addr_rd  output  ADDR_WIDTH  program-memory read byte address.
- rd_ins  output  1  one-cycle read request.
- rd_idle  input  1  memory read port idle; drops the cycle after rd_ins and returns high with data valid.
- data_bus_rd  input  INSTRUCTION_WIDTH  read data, valid in the first cycle rd_idle is high again.
- data_bus_in  output  DATA_WIDTH  byte to UART TX.
- TX_use  output  1  one-cycle strobe loading data_bus_in into UART TX.
- TX_complete  input  1  one-cycle pulse when UART TX has finished the current byte.

Behaviour:
- Reset: synchronous; every output is forced to 0 at the clk edge with rst_n=0. This includes busy, done, addr_rd, rd_ins, data_bus_in and TX_use. FSM goes to IDLE and all counters clear.
- Reset mid-operation: abandons the dump immediately. No done pulse, no further rd_ins or TX_use.
- FSM states:
  - IDLE:
    - start=1 and word_count=0: pulse done next cycle, busy stays 0, no memory or UART traffic.
    - start=1 and word_count>0: latch {start_addr[ADDR_WIDTH-1:2],2'b00} into addr_rd and word_count into remaining; busy=1; go to REQ.
  - REQ:
    - Wait for rd_idle=1, then assert rd_ins for exactly one cycle; go to WAIT_RD.
  - WAIT_RD:
    - Wait at least one cycle for rd_idle low, then the first cycle rd_idle=1.
    - Capture data_bus_rd into a shift register, set byte_idx=0, go to SEND.
  - SEND:
    - Drive data_bus_in = shift[7:0] and TX_use=1 for one cycle; go to WAIT_TX.
    - data_bus_in holds its value until the next TX_use.
  - WAIT_TX:
    - On TX_complete=1: shift right by 8 and increment byte_idx.
    - byte_idx<3 → SEND. byte_idx=3 → NEXT.
    - TX_complete while not in WAIT_TX is ignored.
  - NEXT:
    - addr_rd += 4, wrapping modulo 2^ADDR_WIDTH; remaining -= 1.
    - remaining reaches 0 → DONE, else → REQ.
  - DONE:
    - done=1 for one cycle, busy=0, return to IDLE.
- start while busy: ignored (no queuing).
- Byte order: word W is sent as W[7:0], W[15:8], W[23:16], W[31:24].
- Throughput: at most one outstanding memory read and one outstanding UART byte; no overlap between reading and sending.
- Minimum latency from start to first TX_use is 4 cycles with rd_idle high and a 1-cycle read.
- Address wrap: start_addr=0xFC with 2 words reads 0xFC then 0x00.

Optional Feature:
- Macro: PM_DUMP_CHECKSUM_EN.
- Defined:
  - After the last word's 4th TX_complete, the FSM enters CSUM instead of DONE.
  - CSUM sends one extra byte: the 8-bit sum modulo 256 of all data bytes sent in this dump. The accumulator clears on accepted start.
  - CSUM waits for TX_complete, then goes to DONE.
  - word_count=0 still completes with no bytes and no checksum.
- Undefined: no CSUM state and no accumulator logic; behaviour exactly as above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-dump (after 2nd byte) → busy=0, done=0, TX_use=0, rd_ins=0. No further strobes until a new start.
- Single word: start_addr=0x10, word_count=1, memory returns 0xA1B2C3D4 → rd_ins once at addr 0x10. TX bytes D4, C3, B2, A1, each after the prior TX_complete; done pulses once; busy low after.
- Multi word with wrap: start_addr=0xFC, word_count=2, data 0x11223344 then 0x55667788 → reads at 0xFC then 0x00; 8 bytes 44 33 22 11 88 77 66 55.
- Zero count: start with word_count=0 → done pulses the next cycle; no rd_ins or TX_use; busy stays 0.
- Backpressure: rd_idle held low 5 cycles before the request and TX_complete delayed 20 cycles → rd_ins issues only after rd_idle=1. TX_use is never reasserted before TX_complete; start pulses while busy are ignored.
- Checksum (PM_DUMP_CHECKSUM_EN): word_count=1, data 0x01020304 → bytes 04 03 02 01 followed by 0x0A, then done.
